// File: rtl/race_sequencer.sv
// Race start/finish sequencer: start-light countdown, false-start detection,
// finish-line flags and winner arbitration for a two-player race.
module race_sequencer #(
  parameter int FINISH_LINE_POS = 2000,
  parameter int TICKS_PER_LIGHT = 1000,
  parameter int LIGHT_STEPS     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1khz,
  input  logic        start_game,
  input  logic        restart,
  input  logic        throttle_p1,
  input  logic        throttle_p2,
  input  logic [31:0] position_p1,
  input  logic [31:0] position_p2,
  output logic [2:0]  light_count,
  output logic        race_active,
  output logic        p1_finished,
  output logic        p2_finished,
  output logic        end_game,
  output logic [1:0]  winner,
  output logic [1:0]  false_start,
  output logic [1:0]  state
);

  localparam int TW = (TICKS_PER_LIGHT > 1) ? $clog2(TICKS_PER_LIGHT) : 1;

  localparam logic [1:0] S_IDLE      = 2'b00;
  localparam logic [1:0] S_COUNTDOWN = 2'b01;
  localparam logic [1:0] S_RACE      = 2'b10;
  localparam logic [1:0] S_FINISHED  = 2'b11;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_LIGHT - 1);
  localparam logic [2:0]    LIGHT_LAST = 3'(LIGHT_STEPS);
  localparam logic [31:0]   FINISH_POS = 32'(FINISH_LINE_POS);

  logic [1:0]    r_state,  w_state;
  logic [TW-1:0] r_tick,   w_tick;
  logic [2:0]    r_light,  w_light;
  logic          r_active, w_active;
  logic          r_p1f,    w_p1f;
  logic          r_p2f,    w_p2f;
  logic          r_end,    w_end;
  logic [1:0]    r_winner, w_winner;
  logic [1:0]    r_fs,     w_fs;

  logic          w_cross_p1, w_cross_p2;
  logic [2:0]    w_light_inc;
  logic [1:0]    w_order;

  assign w_cross_p1  = (position_p1 >= FINISH_POS);
  assign w_cross_p2  = (position_p2 >= FINISH_POS);
  assign w_light_inc = r_light + 3'd1;
  // Finish order as seen on the first finishing cycle: {p2, p1} maps onto the winner code.
  assign w_order     = {w_cross_p2, w_cross_p1};

  always_comb begin
    w_state  = r_state;
    w_tick   = r_tick;
    w_light  = r_light;
    w_active = r_active;
    w_p1f    = r_p1f;
    w_p2f    = r_p2f;
    w_end    = r_end;
    w_winner = r_winner;
    w_fs     = r_fs;
    case (r_state)
      S_IDLE: begin
        w_tick  = '0;
        w_light = '0;
        if (start_game) w_state = S_COUNTDOWN;
      end
      S_COUNTDOWN: begin
        if (!start_game) begin
          w_state = S_IDLE;
          w_tick  = '0;
          w_light = '0;
          w_fs    = 2'b00;
        end else begin
          w_fs = r_fs | {throttle_p2, throttle_p1};
          if (tick_1khz) begin
            if (r_tick == TICK_LAST) begin
              w_tick  = '0;
              w_light = w_light_inc;
              if (w_light_inc == LIGHT_LAST) begin
                w_state  = S_RACE;
                w_active = 1'b1;
              end
            end else begin
              w_tick = r_tick + TW'(1);
            end
          end
        end
      end
      S_RACE: begin
        if (r_p1f && r_p2f) begin
          w_state  = S_FINISHED;
          w_active = 1'b0;
          w_end    = 1'b1;
        end else begin
          w_p1f = r_p1f | w_cross_p1;
          w_p2f = r_p2f | w_cross_p2;
          // A single false starter forfeits to the other player; otherwise order decides.
          if (!r_p1f && !r_p2f && (w_cross_p1 || w_cross_p2)) begin
            case (r_fs)
              2'b01:   w_winner = 2'b10;
              2'b10:   w_winner = 2'b01;
              default: w_winner = w_order;
            endcase
          end
        end
      end
      default: ;
    endcase
    if (restart) begin
      w_state  = S_IDLE;
      w_tick   = '0;
      w_light  = '0;
      w_active = 1'b0;
      w_p1f    = 1'b0;
      w_p2f    = 1'b0;
      w_end    = 1'b0;
      w_winner = 2'b00;
      w_fs     = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_light  <= '0;
      r_active <= 1'b0;
      r_p1f    <= 1'b0;
      r_p2f    <= 1'b0;
      r_end    <= 1'b0;
      r_winner <= 2'b00;
      r_fs     <= 2'b00;
    end else begin
      r_state  <= w_state;
      r_tick   <= w_tick;
      r_light  <= w_light;
      r_active <= w_active;
      r_p1f    <= w_p1f;
      r_p2f    <= w_p2f;
      r_end    <= w_end;
      r_winner <= w_winner;
      r_fs     <= w_fs;
    end
  end

  assign state       = r_state;
  assign light_count = r_light;
  assign race_active = r_active;
  assign p1_finished = r_p1f;
  assign p2_finished = r_p2f;
  assign end_game    = r_end;
  assign winner      = r_winner;
  assign false_start = r_fs;

endmodule
